// File: rtl/nor_arb_pkg.sv
// Shared definitions for the NOR-based OR arbiter: FSM states and default sizing.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package nor_arb_pkg;

  // One operation walks IDLE -> PASS1 -> PASS2 -> RESP -> IDLE.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PASS1 = 2'd1,
    PASS2 = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam int DEF_N_REQ = 4;
  localparam int DEF_WIDTH = 8;

endpackage

// File: rtl/nor_unit.sv
// Bitwise two-input NOR, the single logic unit shared by both passes of an operation.
// Latency: combinational, zero cycles.
// Backpressure: none; output follows inputs.
// Ports: a, b - WIDTH-bit operands; y - WIDTH-bit result ~(a | b).
module nor_unit #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  assign y = ~(a | b);

endmodule

// File: rtl/nor_or_arbiter.sv
// Arbitrates N_REQ requesters and computes a OR b for the winner as NOR(NOR(a,b),NOR(a,b)) on one NOR unit.
// Latency: gnt in cycle 0, rsp_valid in cycle 3; one operation per 4 cycles.
// Backpressure: none downstream; requesters wait (gnt=0) while busy, req is ignored outside IDLE.
// Ports: clk/rst (async, active-high); req, a_in, b_in (packed per requester, WIDTH bits each);
//        gnt (one-hot), busy, rsp_valid (1-cycle strobe), rsp_id, y_out (held until next response).
// Build option: define NOR_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins, no rotation pointer);
//               default is round-robin starting at index 0 after reset.
module nor_or_arbiter
  import nor_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*WIDTH-1:0]    a_in,
  input  logic [N_REQ*WIDTH-1:0]    b_in,
  output logic [N_REQ-1:0]          gnt,
  output logic                      busy,
  output logic                      rsp_valid,
  output logic [$clog2(N_REQ)-1:0]  rsp_id,
  output logic [WIDTH-1:0]          y_out
);

  localparam int IDW = $clog2(N_REQ);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q, temp_q, y_q;
  logic [IDW-1:0]   id_q, rsp_id_q;
  logic [WIDTH-1:0] nor_a, nor_b, nor_y;
  logic             win_vld;
  logic [IDW-1:0]   win_idx;
  logic [WIDTH-1:0] win_a, win_b;

`ifndef NOR_ARB_FIXED_PRIO_EN
  logic [IDW-1:0]   ptr;
`endif

  // Winner search: first requester found walking upward from the start point.
  always_comb begin
    int idx;
    idx     = 0;
    win_vld = 1'b0;
    win_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
`ifdef NOR_ARB_FIXED_PRIO_EN
      idx = k;
`else
      idx = (int'(ptr) + k) % N_REQ;
`endif
      if (!win_vld && req[idx]) begin
        win_vld = 1'b1;
        win_idx = IDW'(idx);
      end
    end
  end

  assign win_a = a_in[win_idx*WIDTH +: WIDTH];
  assign win_b = b_in[win_idx*WIDTH +: WIDTH];

  // PASS1 feeds the latched operands; PASS2 feeds temp into both inputs.
  assign nor_a = (state == PASS1) ? a_q : temp_q;
  assign nor_b = (state == PASS1) ? b_q : temp_q;

  nor_unit #(.WIDTH(WIDTH)) u_nor (
    .a (nor_a),
    .b (nor_b),
    .y (nor_y)
  );

  always_comb begin
    state_nxt = state;
    gnt       = '0;
    case (state)
      IDLE: begin
        if (win_vld) begin
          gnt[win_idx] = 1'b1;
          state_nxt    = PASS1;
        end
      end
      PASS1:   state_nxt = PASS2;
      PASS2:   state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      id_q     <= '0;
      temp_q   <= '0;
      y_q      <= '0;
      rsp_id_q <= '0;
`ifndef NOR_ARB_FIXED_PRIO_EN
      ptr      <= '0;
`endif
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (win_vld) begin
            a_q  <= win_a;
            b_q  <= win_b;
            id_q <= win_idx;
`ifndef NOR_ARB_FIXED_PRIO_EN
            ptr  <= (win_idx == IDW'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
`endif
          end
        end
        PASS1: temp_q <= nor_y;
        PASS2: begin
          // Result and owner update together so they stay paired until the next response.
          y_q      <= nor_y;
          rsp_id_q <= id_q;
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign rsp_valid = (state == RESP);
  assign y_out     = y_q;
  assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_nor_or_arbiter.sv
// Scoreboard bench for nor_or_arbiter (N_REQ=4, WIDTH=8): stimulus pushes expected responses,
// an independent monitor pops and checks them whenever rsp_valid is seen.
module tb_nor_or_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] a_in, b_in;
  logic [3:0]  gnt;
  logic        busy, rsp_valid;
  logic [1:0]  rsp_id;
  logic [7:0]  y_out;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int         id;
    logic [7:0] y;
    int         cyc;
  } exp_t;
  exp_t sbq[$];

  nor_or_arbiter #(.N_REQ(4), .WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .a_in      (a_in),
    .b_in      (b_in),
    .gnt       (gnt),
    .busy      (busy),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .y_out     (y_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every response strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got rsp_id %0d y_out %0h expected no response", rsp_id, y_out);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("rsp_y", 32'(y_out), 32'(e.y));
        chk("rsp_id", 32'(rsp_id), 32'(e.id));
        chk("rsp_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
    a_in[i*8 +: 8] = a;
    b_in[i*8 +: 8] = b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation from IDLE; req switches to nxt after the grant edge.
  // Returns at cycle 4 of the operation (IDLE again), just after the edge.
  task automatic issue(input logic [3:0] r, input logic [3:0] nxt, input logic [3:0] exp_gnt,
                       input int exp_id, input logic [7:0] exp_y);
    exp_t e;
    int   n;
    n = 0;
    while (busy === 1'b1 && n < 8) begin
      tick();
      n++;
    end
    chk("idle_before_issue", 32'(busy), 32'd0);
    req = r;
    @(negedge clk);
    chk("gnt_cycle0", 32'(gnt), 32'(exp_gnt));
    e.id  = exp_id;
    e.y   = exp_y;
    e.cyc = cyc + 3;
    sbq.push_back(e);
    tick();
    req = nxt;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk("gnt_busy_phase", 32'(gnt), 32'd0);
      chk("busy_phase", 32'(busy), 32'd1);
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst  = 1'b1;
    req  = '0;
    a_in = '0;
    b_in = '0;
    #12;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_y_out", 32'(y_out), 32'd0);
    tick();
    rst = 1'b0;

    // Idle with no requests.
    repeat (2) begin
      @(negedge clk);
      chk("idle_noreq_busy", 32'(busy), 32'd0);
      chk("idle_noreq_gnt", 32'(gnt), 32'd0);
    end
    tick();

    // Single requester 0: 0x0F | 0xF0.
    set_op(0, 8'h0F, 8'hF0);
    issue(4'b0001, 4'b0000, 4'b0001, 0, 8'hFF);

    // Requester 2: 0x0C | 0x0A, then all zeros.
    set_op(2, 8'h0C, 8'h0A);
    issue(4'b0100, 4'b0000, 4'b0100, 2, 8'h0E);
    @(negedge clk);
    chk("y_hold", 32'(y_out), 32'h0E);
    chk("id_hold", 32'(rsp_id), 32'd2);
    tick();
    set_op(2, 8'h00, 8'h00);
    issue(4'b0100, 4'b0000, 4'b0100, 2, 8'h00);

    // Pointer wrap: grant 3, then 0 and 3 both requesting -> 0.
    set_op(3, 8'h50, 8'h05);
    issue(4'b1000, 4'b0000, 4'b1000, 3, 8'h55);
    set_op(0, 8'h81, 8'h18);
    issue(4'b1001, 4'b0000, 4'b0001, 0, 8'h99);

    // Requester 1 rises while requester 0 is in flight: no grant until IDLE.
    set_op(0, 8'h11, 8'h22);
    set_op(1, 8'hA0, 8'h0A);
    issue(4'b0001, 4'b0010, 4'b0001, 0, 8'h33);
    issue(4'b0010, 4'b0000, 4'b0010, 1, 8'hAA);

    // All four held after a reset.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_op(0, 8'h01, 8'h10);
    set_op(1, 8'h22, 8'h04);
    set_op(2, 8'h40, 8'h08);
    set_op(3, 8'h80, 8'h03);
`ifdef NOR_ARB_FIXED_PRIO_EN
    for (int g = 0; g < 5; g++) issue(4'b1111, 4'b1111, 4'b0001, 0, 8'h11);
`else
    issue(4'b1111, 4'b1111, 4'b0001, 0, 8'h11);
    issue(4'b1111, 4'b1111, 4'b0010, 1, 8'h26);
    issue(4'b1111, 4'b1111, 4'b0100, 2, 8'h48);
    issue(4'b1111, 4'b1111, 4'b1000, 3, 8'h83);
    issue(4'b1111, 4'b0000, 4'b0001, 0, 8'h11);
`endif

    // Reset during PASS2 aborts the operation without a response.
    set_op(0, 8'h0F, 8'h30);
    req = 4'b0001;
    @(negedge clk);
    chk("abort_gnt", 32'(gnt), 32'b0001);
    tick();
    req = 4'b0000;
    tick();
    rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_y_out", 32'(y_out), 32'd0);
    chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    tick();
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("post_abort_idle", 32'(busy), 32'd0);
    end
    tick();
    set_op(2, 8'h21, 8'h12);
    issue(4'b0100, 4'b0000, 4'b0100, 2, 8'h33);

    repeat (6) tick();
    chk("scoreboard_drained", sbq.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nor_or_arbiter.md
NOR_OR_ARBITER -- requirements
Module: nor_or_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters (2..16).
REQ-002 SHALL have parameter WIDTH, default 8, operand/result bit width.
REQ-003 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-004 SHALL have port rst, input, 1, reset, asynchronous, active-high.
REQ-005 SHALL have port req, input, N_REQ, per-requester request level.
REQ-006 SHALL have port a_in, input, N_REQ*WIDTH, packed operand A (requester i at bits [i*WIDTH +: WIDTH]).
REQ-007 SHALL have port b_in, input, N_REQ*WIDTH, packed operand B, same packing.
REQ-008 SHALL have port gnt, output, N_REQ, one-hot grant, at most one bit set.
REQ-009 SHALL have port busy, output, 1, high when the state is not IDLE.
REQ-010 SHALL have port rsp_valid, output, 1, one-cycle result strobe.
REQ-011 SHALL have port rsp_id, output, clog2(N_REQ), index of the requester owning the result.
REQ-012 SHALL have port y_out, output, WIDTH, result equal to a OR b, computed as NOR(NOR(a,b), NOR(a,b)).

Function
REQ-013 SHALL implement FSM IDLE -> PASS1 -> PASS2 -> RESP -> IDLE, with one cycle per state outside IDLE.
REQ-014 SHALL assert gnt combinationally only in IDLE while req is nonzero, and SHALL latch the granted operands and index on that clock edge.
REQ-015 SHALL, in PASS1, register temp = ~(a | b) through the shared NOR unit.
REQ-016 SHALL, in PASS2, register y = ~(temp | temp) through the same NOR unit, with inputs muxed.
REQ-017 SHALL, in RESP, drive rsp_valid=1 with y_out and rsp_id valid; latency is gnt at cycle 0 to rsp_valid at cycle 3.
REQ-018 SHALL hold y_out and rsp_id after RESP until the next RESP.
REQ-019 SHALL keep gnt=0 in PASS1, PASS2 and RESP; req changes in those states are ignored.
REQ-020 SHALL allow the earliest next grant at cycle 4, giving 1 operation per 4 cycles.
REQ-021 SHALL arbitrate round-robin by default: search starts at pointer ptr, and on grant ptr <= granted index + 1, wrapping from N_REQ-1 to 0.
REQ-022 SHALL treat a requester that still holds req after its grant as a new request, eligible at the next IDLE.
REQ-023 SHALL stay in IDLE with all outputs inactive while req == 0.

Reset
REQ-024 SHALL, on rst, force state=IDLE, ptr=0, gnt=0, busy=0, rsp_valid=0, rsp_id=0, y_out=0, and clear temp and the latched operands.
REQ-025 SHALL abort any operation on reset mid-operation, with no rsp_valid pulse for it.
REQ-026 SHALL start arbitration from index 0 after reset release.

Configuration
REQ-027 SHALL, when macro NOR_ARB_FIXED_PRIO_EN is defined, use fixed priority (lowest requesting index wins) and omit ptr.
REQ-028 SHALL, when NOR_ARB_FIXED_PRIO_EN is undefined, use round-robin per REQ-021.

Structure
REQ-029 SHALL place the FSM state enum (IDLE, PASS1, PASS2, RESP) and default N_REQ/WIDTH constants in shared package nor_arb_pkg.
REQ-030 SHALL instantiate exactly one sub-module nor_unit (WIDTH-bit bitwise NOR2, combinational), shared across both passes.

Verification (N_REQ=4, WIDTH=8)
REQ-031 SHALL cover: req=0001, a0=0x0F, b0=0xF0 -> gnt=0001 at cycle 0; rsp_valid at cycle 3 with y_out=0xFF, rsp_id=0.
REQ-032 SHALL cover: req=0100, a2=0x0C, b2=0x0A -> y_out=0x0E, rsp_id=2; also a2=b2=0x00 -> y_out=0x00.
REQ-033 SHALL cover: req=1111 held continuously -> grants 0,1,2,3,0 every 4 cycles round-robin; with NOR_ARB_FIXED_PRIO_EN grants 0,0,0.
REQ-034 SHALL cover: ptr wrap, last grant 3 then req=1001 -> gnt=0001.
REQ-035 SHALL cover: rst pulsed during PASS2 -> no rsp_valid, busy=0 and y_out=0 immediately; after release req=0100 -> gnt=0100.
REQ-036 SHALL cover: req1 raised during PASS1 of req0's operation -> gnt stays 0 until IDLE, then gnt=0010 at cycle 4.
